// File: rtl/axi_pkg.sv
// Shared AXI3 definitions: burst types, response codes and the WRAP-length legality rule.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_illegal(input logic [1:0] burst, input logic [3:0] len);
    return (burst == BURST_WRAP) &&
           !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
  endfunction

endpackage

// File: rtl/axi_sram_bridge_if.sv
// AXI3 slave-side bus bundle for the SRAM bridge (AR, R, AW, W, B channels).
interface axi_sram_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts of 32-bit beats.
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [3:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  always_comb begin
    incr_addr = addr + 32'd4;
    // Legal wrap lengths make (len+1)*4-1 equal to {len, 2'b11}.
    wrap_mask = {26'd0, len, 2'b11};
    if (burst == BURST_FIXED)
      next_addr = addr;
    else if (burst == BURST_WRAP && !wrap_illegal(burst, len))
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    else
      next_addr = incr_addr;
  end

endmodule

// File: rtl/axi_sram_bridge.sv
// AXI3 slave to single-port synchronous SRAM bridge; one burst in flight, 2-deep read buffer.
module axi_sram_bridge
  import axi_pkg::*;
#(
  parameter int unsigned SRAM_AW = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  axi_sram_bridge_if.slave   axi,
  output logic               sram_en,
  output logic [3:0]         sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] WR    = 2'd2;
  localparam logic [1:0] WRESP = 2'd3;

  logic [1:0]  state;
  logic        live, rr_wr, err_q;
  logic [3:0]  id_q, len_q, beat_q;
  logic [1:0]  burst_q;
  logic [31:0] addr_q;
  logic [4:0]  issued_q;
  logic        inflight_q, inflight_last_q;
  logic [31:0] buf_data [2];
  logic [1:0]  buf_last;
  logic [1:0]  buf_cnt;
  logic        wptr, rptr;

  logic        idle, ar_go, aw_go, w_go, pop, rd_more, rd_issue, issue_last, w_err;
  logic [1:0]  occ;
  logic [31:0] gen_addr, next_addr;
  logic [3:0]  gen_len;
  logic [1:0]  gen_burst;
  logic        unused_attrs;

  assign unused_attrs = ^{axi.arsize, axi.arlock, axi.arcache, axi.arprot,
                          axi.awsize, axi.awlock, axi.awcache, axi.awprot};

  assign idle        = live && (state == IDLE);
  assign axi.arready = idle && !(axi.awvalid && rr_wr);
  assign axi.awready = idle && !(axi.arvalid && !rr_wr);
  assign ar_go       = axi.arvalid && axi.arready;
  assign aw_go       = axi.awvalid && axi.awready;
  assign axi.wready  = (state == WR);
  assign w_go        = axi.wvalid && axi.wready;

  assign axi.rvalid  = (buf_cnt != 2'd0);
  assign axi.rdata   = buf_data[rptr];
  assign axi.rlast   = axi.rvalid && buf_last[rptr];
  assign axi.rid     = id_q;
  assign axi.rresp   = err_q ? RESP_SLVERR : RESP_OKAY;
  assign axi.bvalid  = (state == WRESP);
  assign axi.bid     = id_q;
  assign axi.bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
  assign pop         = axi.rvalid && axi.rready;

  // Occupancy counts the beat leaving this cycle so a steady rready streams without bubbles.
  assign occ        = buf_cnt + {1'b0, inflight_q} - {1'b0, pop};
  assign rd_more    = (state == RD) && (issued_q <= {1'b0, len_q}) && (occ < 2'd2);
  assign rd_issue   = ar_go || rd_more;

  // The first read beat issues in the AR handshake cycle, straight from araddr.
  assign gen_addr   = (state == IDLE) ? axi.araddr  : addr_q;
  assign gen_len    = (state == IDLE) ? axi.arlen   : len_q;
  assign gen_burst  = (state == IDLE) ? axi.arburst : burst_q;
  assign issue_last = (issued_q[3:0] == gen_len);
  assign w_err      = (axi.wid != id_q) || (axi.wlast != (beat_q == len_q));

  assign sram_en    = rd_issue || w_go;
  assign sram_we    = w_go ? axi.wstrb : '0;
  assign sram_addr  = gen_addr[SRAM_AW+1:2];
  assign sram_wdata = axi.wdata;

  axi_burst_addr_gen u_addr_gen (
    .addr      (gen_addr),
    .len       (gen_len),
    .burst     (gen_burst),
    .next_addr (next_addr)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state           <= IDLE;
      live            <= 1'b0;
      rr_wr           <= 1'b0;
      err_q           <= 1'b0;
      id_q            <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      burst_q         <= '0;
      addr_q          <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_last        <= '0;
      buf_cnt         <= '0;
      wptr            <= 1'b0;
      rptr            <= 1'b0;
    end else begin
      live            <= 1'b1;
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && issue_last;
      if (inflight_q) begin
        buf_data[wptr] <= sram_rdata;
        buf_last[wptr] <= inflight_last_q;
        wptr           <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      buf_cnt <= buf_cnt + {1'b0, inflight_q} - {1'b0, pop};
      if (idle && axi.arvalid && axi.awvalid)
        rr_wr <= ~rr_wr;

      case (state)
        IDLE: begin
          if (ar_go) begin
            state    <= RD;
            id_q     <= axi.arid;
            len_q    <= axi.arlen;
            burst_q  <= axi.arburst;
            addr_q   <= next_addr;
            issued_q <= 5'd1;
            err_q    <= wrap_illegal(axi.arburst, axi.arlen);
          end else if (aw_go) begin
            state   <= WR;
            id_q    <= axi.awid;
            len_q   <= axi.awlen;
            burst_q <= axi.awburst;
            addr_q  <= axi.awaddr;
            beat_q  <= '0;
            err_q   <= wrap_illegal(axi.awburst, axi.awlen);
          end
        end
        RD: begin
          if (rd_more) begin
            addr_q   <= next_addr;
            issued_q <= issued_q + 5'd1;
          end
          if (pop && axi.rlast) begin
            state    <= IDLE;
            issued_q <= '0;
          end
        end
        WR: begin
          if (w_go) begin
            addr_q <= next_addr;
            beat_q <= beat_q + 4'd1;
            if (w_err)
              err_q <= 1'b1;
            if (beat_q == len_q)
              state <= WRESP;
          end
        end
        default: begin
          if (axi.bready)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_sram_bridge.md
AXI_SRAM_BRIDGE -- requirements
Module: axi_sram_bridge

Interface
REQ-001 Parameter SRAM_AW, default 16: SRAM word-address width (capacity 4*2^SRAM_AW bytes).
REQ-002 aclk  in  1  clock; all logic on rising edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  in  4/32/4/3/2/2/4/3/1  AXI3 read address; arready  out  1.
REQ-005 rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data; rready  in  1.
REQ-006 awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  in  4/32/4/3/2/2/4/3/1  write address; awready  out  1.
REQ-007 wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data; wready  out  1.
REQ-008 bid/bresp/bvalid  out  4/2/1  write response; bready  in  1.
REQ-009 sram_en  out  1; sram_we  out  4 byte enables; sram_addr  out  SRAM_AW; sram_wdata  out  32; sram_rdata  in  32, valid the cycle after sram_en with sram_we==0.

Function
REQ-010 FSM states IDLE, RD, WR, WRESP; one burst in flight at a time.
REQ-011 IDLE: arready/awready high only in IDLE for the selected channel; both valid same cycle -> round-robin, read wins first after reset, then alternates on each double request.
REQ-012 Word address = addr[SRAM_AW+1:2]; upper bits ignored (aliasing, no DECERR).
REQ-013 Beat address: FIXED constant; INCR +4 per beat; WRAP wraps within (len+1)*4-byte boundary; WRAP with len not in {1,3,7,15} treated as INCR, response SLVERR on all beats.
REQ-014 arsize/awsize other than 2 treated as 32-bit access; byte selection via wstrb only; arlock/arcache/arprot/awlock/awcache/awprot ignored.
REQ-015 RD: 2-entry read-data buffer; SRAM read issued when buffered + in-flight < 2 and beats remain; rvalid whenever buffer non-empty.
REQ-016 Read latency: AR handshake at cycle T -> first rvalid at T+2; with rready held high, one beat per cycle, no bubbles.
REQ-017 rid = latched arid; rlast on beat arlen; rresp OKAY (00) unless REQ-013; rvalid/rdata held stable until rready.
REQ-018 RD -> IDLE on handshake of rlast beat; next AR accepted no earlier than the following cycle.
REQ-019 WR: wready high; each W handshake writes SRAM same cycle (sram_en=1, sram_we=wstrb, sram_wdata=wdata).
REQ-020 Beat counter compares against latched awlen; write ends on beat awlen regardless of wlast.
REQ-021 SLVERR latched if any beat has wid != awid or wlast asserted on wrong beat; data still written.
REQ-022 WRESP: bvalid high, bid = awid, bresp OKAY/SLVERR; -> IDLE on bready; wready low.
REQ-023 wvalid in IDLE/RD/WRESP ignored (wready low); W beats never accepted before AW.
REQ-024 sram_en low whenever no access issued; sram_we zero on reads.

Reset
REQ-025 aresetn low: state IDLE, arready=awready=wready=rvalid=bvalid=0, rlast=0, rid/bid/rresp/bresp=0, sram_en=0, sram_we=0, read buffer emptied, counters cleared, round-robin pointer to read.
REQ-026 Reset mid-burst abandons burst immediately; no further beats or responses; arready/awready first asserted the cycle after aresetn rises.

Structure
REQ-027 Burst-type enum (FIXED/INCR/WRAP) and resp constants (OKAY/EXOKAY/SLVERR/DECERR) in shared package axi_pkg.
REQ-028 Next-address computation in sub-module axi_burst_addr_gen (addr, len, burst -> next addr), shared by both channels.

Verification
REQ-029 Preload word 0x100..0x10C with A,B,C,D; AR INCR addr 0x100 len 3 id 5, rready high -> rdata A,B,C,D on consecutive cycles from T+2, rid 5, rlast on 4th.
REQ-030 AR WRAP addr 0x108 len 3 -> read order 0x108,0x10C,0x100,0x104; rresp OKAY.
REQ-031 AW INCR 0x200 len 1 id 3, W 0x11223344 strb 1111 then 0xAABBCCDD strb 0011 wid 3 -> 0x200=0x11223344, 0x204 low half 0xCCDD; bid 3, bresp OKAY.
REQ-032 arvalid and awvalid both asserted from reset twice -> read first, then write, then read; rready toggling 1/0 -> no beat lost or duplicated.
REQ-033 Write with wid 7 vs awid 3 -> data written, bresp SLVERR (10); AR WRAP len 2 -> SLVERR on all beats.
REQ-034 aresetn low during beat 2 of 8-beat read -> rvalid low next cycle; fresh AR after reset returns correct data.
